// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared state type and timeout default for the memory stage
package mm_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int TIMEOUT_CYC_DEF = 16;

endpackage

// File: rtl/mm_wb_reg.sv
// rtl/mm_wb_reg.sv - MEM/WB pipeline register with load enable
module mm_wb_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] d_data,
    input  logic              d_wreg,
    input  logic [4:0]        d_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_wreg,
    output logic [4:0]        wb_rd
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_data <= '0;
            wb_wreg <= 1'b0;
            wb_rd   <= '0;
        end else if (load) begin
            wb_data <= d_data;
            wb_wreg <= d_wreg;
            wb_rd   <= d_rd;
        end
    end

endmodule

// File: rtl/mm_stage.sv
// rtl/mm_stage.sv - memory pipeline stage; optional access timeout via MM_TIMEOUT_EN
module mm_stage
    import mm_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] rd2_in,
    input  logic              wreg_in,
    input  logic [4:0]        rd_in,
    input  logic              WMM_in,
    input  logic              RMM_in,
    input  logic              MOA_in,
    input  logic              jal_jalr_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              stall,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_wreg,
    output logic [4:0]        wb_rd,
    output logic              err
);

    state_t            state, state_nx;
    logic              mem_op, aligned, both_op, rdata_sel, timeout;
    logic              stall_c, set_err, d_wreg;
    logic [DATA_W-1:0] d_data;

    assign mem_op    = RMM_in | WMM_in;
    assign both_op   = RMM_in & WMM_in;
    assign aligned   = (alu_in[1:0] == 2'b00);
    assign rdata_sel = MOA_in & RMM_in & ~WMM_in & ~jal_jalr_in;

    assign dmem_addr  = alu_in;
    assign dmem_wdata = rd2_in;

`ifdef MM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt;

    assign timeout = (state == ACCESS) && !dmem_ack && (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (state == ACCESS && !dmem_ack && !timeout)
            cnt <= cnt + 1'b1;
        else
            cnt <= '0;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        stall_c  = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        set_err  = 1'b0;
        d_data   = alu_in;
        d_wreg   = wreg_in & (rd_in != 5'd0);
        case (state)
            IDLE: begin
                if (mem_op) begin
                    if (aligned) begin
                        stall_c  = 1'b1;
                        state_nx = ACCESS;
                        set_err  = both_op;
                    end else begin
                        d_data  = '0;
                        d_wreg  = 1'b0;
                        set_err = 1'b1;
                    end
                end
            end
            ACCESS: begin
                dmem_req = 1'b1;
                dmem_we  = WMM_in;
                if (dmem_ack) begin
                    state_nx = IDLE;
                    if (rdata_sel)
                        d_data = dmem_rdata;
                end else if (timeout) begin
                    // abandoned access retires as a non-writing bubble
                    state_nx = IDLE;
                    d_data   = '0;
                    d_wreg   = 1'b0;
                    set_err  = 1'b1;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // upstream must never be held while reset is asserted
    assign stall = stall_c & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if (set_err)
            err <= 1'b1;
    end

    mm_wb_reg #(.DATA_W(DATA_W)) u_wb_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (~stall),
        .d_data  (d_data),
        .d_wreg  (d_wreg),
        .d_rd    (rd_in),
        .wb_data (wb_data),
        .wb_wreg (wb_wreg),
        .wb_rd   (wb_rd)
    );

endmodule

// File: tb/tb_mm_stage.sv
// tb/tb_mm_stage.sv - self-checking bench for mm_stage (directed table, random ops, reset and timeout sequences)
module tb_mm_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_in, rd2_in, dmem_addr, dmem_wdata, dmem_rdata, wb_data;
    logic        wreg_in, WMM_in, RMM_in, MOA_in, jal_jalr_in;
    logic [4:0]  rd_in, wb_rd;
    logic        dmem_req, dmem_we, dmem_ack, stall, wb_wreg, err;

    int n_cmp  = 0;
    int n_fail = 0;
    logic exp_err = 1'b0;

    mm_stage dut (
        .clk(clk), .rst(rst), .alu_in(alu_in), .rd2_in(rd2_in), .wreg_in(wreg_in),
        .rd_in(rd_in), .WMM_in(WMM_in), .RMM_in(RMM_in), .MOA_in(MOA_in),
        .jal_jalr_in(jal_jalr_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .stall(stall), .wb_data(wb_data), .wb_wreg(wb_wreg),
        .wb_rd(wb_rd), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rd2;
        logic        wreg;
        logic [4:0]  rd;
        logic        wmm, rmm, moa, jal;
        int          k;
        logic [31:0] rdata;
        logic [31:0] exp_data;
        logic        exp_wreg;
        logic        exp_err;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] alu, input logic [31:0] rd2, input logic wreg,
                                input logic [4:0] rd, input logic wmm, input logic rmm,
                                input logic moa, input logic jal, input int k,
                                input logic [31:0] rdata, input logic [31:0] ed,
                                input logic ew, input logic ee);
        vec_t v;
        v.alu = alu; v.rd2 = rd2; v.wreg = wreg; v.rd = rd; v.wmm = wmm; v.rmm = rmm;
        v.moa = moa; v.jal = jal; v.k = k; v.rdata = rdata;
        v.exp_data = ed; v.exp_wreg = ew; v.exp_err = ee;
        return v;
    endfunction

    // Reference: what the stage must retire for one instruction, from the writeback rules
    function automatic void model(inout vec_t v);
        logic mis;
        mis = (v.rmm | v.wmm) && (v.alu[1:0] != 2'b00);
        if (mis) begin
            v.exp_data = 32'h0; v.exp_wreg = 1'b0; v.exp_err = 1'b1;
        end else begin
            v.exp_wreg = v.wreg && (v.rd != 5'd0);
            v.exp_err  = v.rmm && v.wmm;
            if (v.jal)                         v.exp_data = v.alu;
            else if (v.moa && v.rmm && !v.wmm) v.exp_data = v.rdata;
            else                               v.exp_data = v.alu;
        end
    endfunction

    task automatic set_nop();
        RMM_in = 1'b0; WMM_in = 1'b0; MOA_in = 1'b0; jal_jalr_in = 1'b0;
        wreg_in = 1'b0; rd_in = 5'd0; alu_in = 32'h0; rd2_in = 32'h0; dmem_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_err = 1'b0;
    endtask

    // Applies one instruction from just after a rising edge; returns just after its retiring edge
    task automatic run_op(input vec_t v, input string tag);
        logic acc;
        int   ncyc;
        acc  = (v.rmm | v.wmm) && (v.alu[1:0] == 2'b00);
        ncyc = acc ? 1 + v.k : 1;
        alu_in = v.alu; rd2_in = v.rd2; wreg_in = v.wreg; rd_in = v.rd;
        WMM_in = v.wmm; RMM_in = v.rmm; MOA_in = v.moa; jal_jalr_in = v.jal;
        dmem_rdata = v.rdata;
        for (int c = 0; c < ncyc; c++) begin
            dmem_ack = (c == 0) ? 1'($urandom_range(0, 1)) : (c == v.k);
            @(negedge clk);
            chk({tag, ".stall"}, 32'(stall), 32'(acc && c < v.k));
            chk({tag, ".req"}, 32'(dmem_req), 32'(c >= 1));
            chk({tag, ".we"}, 32'(dmem_we), 32'(c >= 1 && v.wmm));
            if (c >= 1) begin
                chk({tag, ".addr"}, dmem_addr, v.alu);
                chk({tag, ".wdata"}, dmem_wdata, v.rd2);
            end
            @(posedge clk); #1;
        end
        dmem_ack = 1'b0;
        exp_err = exp_err | v.exp_err;
        chk({tag, ".wb_data"}, wb_data, v.exp_data);
        chk({tag, ".wb_wreg"}, 32'(wb_wreg), 32'(v.exp_wreg));
        chk({tag, ".wb_rd"}, 32'(wb_rd), 32'(v.rd));
        chk({tag, ".err"}, 32'(err), 32'(exp_err));
    endtask

    initial begin
        vec_t v;
        int   kind;
        logic seen;
        int   nacc;

        tbl[0] = mk(32'h1234, 32'h0, 1, 5, 0, 0, 0, 0, 1, 32'h0, 32'h1234, 1, 0);
        tbl[1] = mk(32'h100, 32'h0, 1, 7, 0, 1, 1, 0, 3, 32'hDEADBEEF, 32'hDEADBEEF, 1, 0);
        tbl[2] = mk(32'h104, 32'hA5A5A5A5, 1, 3, 1, 0, 0, 0, 1, 32'h0, 32'h104, 1, 0);
        tbl[3] = mk(32'h77, 32'h0, 1, 0, 0, 0, 0, 0, 1, 32'h0, 32'h77, 0, 0);
        tbl[4] = mk(32'h208, 32'h0, 1, 1, 0, 1, 1, 1, 2, 32'h55AA55AA, 32'h208, 1, 0);
        tbl[5] = mk(32'h102, 32'h0, 1, 9, 0, 1, 1, 0, 1, 32'h12345678, 32'h0, 0, 1);
        tbl[6] = mk(32'h300, 32'h11, 1, 4, 1, 1, 1, 0, 2, 32'hCAFEF00D, 32'h300, 1, 1);

        set_nop();
        dmem_rdata = 32'h0;
        rst = 1'b1;
        RMM_in = 1'b1; alu_in = 32'h40;
        #12;
        chk("rst.stall", 32'(stall), 32'h0);
        chk("rst.req", 32'(dmem_req), 32'h0);
        chk("rst.we", 32'(dmem_we), 32'h0);
        chk("rst.wb_data", wb_data, 32'h0);
        chk("rst.wb_wreg", 32'(wb_wreg), 32'h0);
        chk("rst.wb_rd", 32'(wb_rd), 32'h0);
        chk("rst.err", 32'(err), 32'h0);
        set_nop();
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 7; i++)
            run_op(tbl[i], $sformatf("vec%0d", i));

        // reset in the middle of an access, then a late ack must be ignored
        do_reset();
        alu_in = 32'h400; RMM_in = 1'b1; MOA_in = 1'b1; wreg_in = 1'b1; rd_in = 5'd6;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midrst.req_before", 32'(dmem_req), 32'h1);
        rst = 1'b1;
        #1;
        chk("midrst.req", 32'(dmem_req), 32'h0);
        chk("midrst.stall", 32'(stall), 32'h0);
        chk("midrst.err", 32'(err), 32'h0);
        chk("midrst.wb_wreg", 32'(wb_wreg), 32'h0);
        set_nop();
        alu_in = 32'h99; wreg_in = 1'b1; rd_in = 5'd2; dmem_ack = 1'b1; dmem_rdata = 32'hBAD0BAD0;
        #2 rst = 1'b0;
        @(negedge clk);
        chk("lateack.req", 32'(dmem_req), 32'h0);
        chk("lateack.stall", 32'(stall), 32'h0);
        @(posedge clk); #1;
        chk("lateack.wb_data", wb_data, 32'h99);
        chk("lateack.wb_wreg", 32'(wb_wreg), 32'h1);
        set_nop();
        exp_err = 1'b0;

`ifdef MM_TIMEOUT_EN
        alu_in = 32'h500; RMM_in = 1'b1; MOA_in = 1'b1; wreg_in = 1'b1; rd_in = 5'd8;
        seen = 1'b0; nacc = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (dmem_req) nacc++;
            if (dmem_req && !stall) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("tmo.aborted", 32'(seen), 32'h1);
        chk("tmo.access_cycles", 32'(nacc), 32'd16);
        chk("tmo.wb_wreg", 32'(wb_wreg), 32'h0);
        chk("tmo.wb_data", wb_data, 32'h0);
        chk("tmo.err", 32'(err), 32'h1);
        set_nop();
        @(negedge clk);
        chk("tmo.req_dropped", 32'(dmem_req), 32'h0);
        @(posedge clk); #1;
        do_reset();
`else
        seen = 1'b0; nacc = 0;
`endif

        for (int i = 0; i < 200; i++) begin
            v.rd2   = $urandom;
            v.wreg  = 1'($urandom_range(0, 1));
            v.rd    = 5'($urandom_range(0, 31));
            v.moa   = 1'($urandom_range(0, 1));
            v.jal   = ($urandom_range(0, 7) == 0);
            v.k     = $urandom_range(1, 5);
            v.rdata = $urandom;
            v.alu   = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) v.alu[1:0] = 2'($urandom_range(1, 3));
            kind  = $urandom_range(0, 9);
            v.rmm = (kind >= 4 && kind <= 6) || kind == 9;
            v.wmm = (kind >= 7);
            model(v);
            run_op(v, $sformatf("rnd%0d", i));
            if ($urandom_range(0, 15) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
